// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//   Central game-flow controller for the VGA space-shooter datapath.
//   Runs the round state machine (attract, play, pause, level transition,
//   lose, win), produces single-cycle movement strobes for ship, bullets and
//   monsters, rate-limits fire requests and pulses a field-reinitialise
//   signal towards the sprite/collision datapath.
//
// Ports
//   iVGA_CLK     in   pixel clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   start        in   start/restart key (level)
//   pause        in   pause key (level), toggles PLAY/PAUSED on each press
//   fire         in   fire key (level)
//   all_cleared  in   datapath reports no monsters left
//   breach       in   datapath reports monster at ship line / ship hit
//   state        out  0 ATTRACT, 1 PLAY, 2 PAUSED, 3 XFER, 4 LOSE, 5 WIN
//   ship_tick    out  ship movement strobe
//   bullet_tick  out  bullet movement strobe
//   monster_tick out  monster movement strobe
//   fire_req     out  accepted-fire pulse
//   clear_field  out  reinitialise monsters and bullets
//   level        out  current level 0..MAX_LEVEL
//   game_over    out  high while in LOSE
//   game_won     out  high while in WIN
// ---------------------------------------------------------------------------
module game_sequencer #(
    parameter int SHIP_DIV      = 1000000,
    parameter int BULLET_DIV    = 100000,
    parameter int MON_DIV_BASE  = 1500000,
    parameter int MON_DIV_STEP  = 250000,
    parameter int MON_DIV_MIN   = 250000,
    parameter int FIRE_COOLDOWN = 8,
    parameter int MAX_LEVEL     = 3,
    parameter int XFER_TICKS    = 64
) (
    input  logic       iVGA_CLK,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       fire,
    input  logic       all_cleared,
    input  logic       breach,
    output logic [2:0] state,
    output logic       ship_tick,
    output logic       bullet_tick,
    output logic       monster_tick,
    output logic       fire_req,
    output logic       clear_field,
    output logic [1:0] level,
    output logic       game_over,
    output logic       game_won
);

    localparam logic [2:0] ST_ATTRACT = 3'd0;
    localparam logic [2:0] ST_PLAY    = 3'd1;
    localparam logic [2:0] ST_PAUSED  = 3'd2;
    localparam logic [2:0] ST_XFER    = 3'd3;
    localparam logic [2:0] ST_LOSE    = 3'd4;
    localparam logic [2:0] ST_WIN     = 3'd5;

    localparam int SHIP_W   = (SHIP_DIV > 1) ? $clog2(SHIP_DIV) : 1;
    localparam int BULLET_W = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
    localparam int MON_MAX  = (MON_DIV_BASE > MON_DIV_MIN) ? MON_DIV_BASE : MON_DIV_MIN;
    localparam int MON_W    = $clog2(MON_MAX + 1);
    localparam int COOL_W   = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam int XFER_W   = (XFER_TICKS > 1) ? $clog2(XFER_TICKS) : 1;

    // Monster period for a level, clamped to the floor so high levels never
    // go below MON_DIV_MIN.
    function automatic logic [MON_W-1:0] mon_div(input logic [1:0] lvl);
        int p;
        p = MON_DIV_BASE - (int'(lvl) * MON_DIV_STEP);
        if (p < MON_DIV_MIN) begin
            p = MON_DIV_MIN;
        end else begin
            p = p;
        end
        return p[MON_W-1:0];
    endfunction

    logic [2:0]          r_state;
    logic [1:0]          r_level;
    logic                r_clear;
    logic                r_over;
    logic                r_won;
    logic                r_start_q;
    logic                r_pause_q;
    logic                r_fire_q;
    logic [SHIP_W-1:0]   r_ship_cnt;
    logic [BULLET_W-1:0] r_bullet_cnt;
    logic [MON_W-1:0]    r_mon_cnt;
    logic [XFER_W-1:0]   r_xfer_cnt;
    logic [COOL_W-1:0]   r_cool;
    logic                r_ship_tick;
    logic                r_bullet_tick;
    logic                r_mon_tick;
    logic                r_fire_req;

    logic                w_start_rise;
    logic                w_pause_rise;
    logic                w_fire_rise;
    logic [MON_W-1:0]    w_mon_div;
    logic                w_play_run;
    logic                w_mon_run;
    logic                w_ship_wrap;
    logic                w_bullet_wrap;
    logic                w_mon_hit;
    logic                w_xfer_done;
    logic                w_fire_accept;
    logic [2:0]          w_state_nxt;
    logic [1:0]          w_level_nxt;
    logic                w_clear_nxt;

    assign w_start_rise = start & ~r_start_q;
    assign w_pause_rise = pause & ~r_pause_q;
    assign w_fire_rise  = fire  & ~r_fire_q;

    assign w_mon_div = mon_div(r_level);

    // Prescalers only advance on cycles that stay in PLAY, so a strobe can
    // never appear together with a state that forbids it.
    assign w_play_run    = (r_state == ST_PLAY) & ~breach & ~all_cleared & ~w_pause_rise;
    assign w_mon_run     = w_play_run | (r_state == ST_XFER);
    assign w_ship_wrap   = w_play_run & (r_ship_cnt == SHIP_W'(SHIP_DIV - 1));
    assign w_bullet_wrap = w_play_run & (r_bullet_cnt == BULLET_W'(BULLET_DIV - 1));
    // >= rather than == so a shorter period after a level change still wraps.
    assign w_mon_hit     = (r_mon_cnt >= (w_mon_div - MON_W'(1)));
    assign w_xfer_done   = (r_state == ST_XFER) & w_mon_hit
                         & (r_xfer_cnt == XFER_W'(XFER_TICKS - 1));
    assign w_fire_accept = (r_state == ST_PLAY) & w_fire_rise & (r_cool == {COOL_W{1'b0}});

    // Next round state, level and field-clear request
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_clear_nxt = 1'b0;
        case (r_state)
            ST_ATTRACT: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_PLAY;
                    w_level_nxt = 2'd0;
                    w_clear_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_ATTRACT;
                end
            end
            ST_PLAY: begin
                if (breach) begin
                    w_state_nxt = ST_LOSE;
                end else if (all_cleared) begin
                    if (r_level == 2'(MAX_LEVEL)) begin
                        w_state_nxt = ST_WIN;
                    end else begin
                        w_state_nxt = ST_XFER;
                    end
                end else if (w_pause_rise) begin
                    w_state_nxt = ST_PAUSED;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PAUSED: begin
                if (w_pause_rise) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_XFER: begin
                if (w_xfer_done) begin
                    w_state_nxt = ST_PLAY;
                    w_level_nxt = r_level + 2'd1;
                    w_clear_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_LOSE, ST_WIN: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_ATTRACT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_ATTRACT;
            end
        endcase
    end

    // Key history for rising-edge detection
    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_start_q <= 1'b0;
            r_pause_q <= 1'b0;
            r_fire_q  <= 1'b0;
        end else begin
            r_start_q <= start;
            r_pause_q <= pause;
            r_fire_q  <= fire;
        end
    end

    // Round state, level, field-clear pulse and end-of-game flags
    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_state <= ST_ATTRACT;
            r_level <= 2'd0;
            r_clear <= 1'b0;
            r_over  <= 1'b0;
            r_won   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_clear <= w_clear_nxt;
            r_over  <= (w_state_nxt == ST_LOSE);
            r_won   <= (w_state_nxt == ST_WIN);
        end
    end

    // Ship and bullet prescalers and their strobes
    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_ship_cnt    <= {SHIP_W{1'b0}};
            r_bullet_cnt  <= {BULLET_W{1'b0}};
            r_ship_tick   <= 1'b0;
            r_bullet_tick <= 1'b0;
        end else begin
            r_ship_tick   <= w_ship_wrap;
            r_bullet_tick <= w_bullet_wrap;
            if (w_ship_wrap) begin
                r_ship_cnt <= {SHIP_W{1'b0}};
            end else if (w_play_run) begin
                r_ship_cnt <= r_ship_cnt + SHIP_W'(1);
            end else begin
                r_ship_cnt <= r_ship_cnt;
            end
            if (w_bullet_wrap) begin
                r_bullet_cnt <= {BULLET_W{1'b0}};
            end else if (w_play_run) begin
                r_bullet_cnt <= r_bullet_cnt + BULLET_W'(1);
            end else begin
                r_bullet_cnt <= r_bullet_cnt;
            end
        end
    end

    // Monster prescaler; it also runs in XFER to time the level transition
    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_mon_cnt  <= {MON_W{1'b0}};
            r_xfer_cnt <= {XFER_W{1'b0}};
            r_mon_tick <= 1'b0;
        end else begin
            r_mon_tick <= w_play_run & w_mon_hit;
            if (w_mon_run) begin
                r_mon_cnt <= w_mon_hit ? {MON_W{1'b0}} : (r_mon_cnt + MON_W'(1));
            end else begin
                r_mon_cnt <= r_mon_cnt;
            end
            if (r_state != ST_XFER) begin
                r_xfer_cnt <= {XFER_W{1'b0}};
            end else if (w_mon_hit) begin
                r_xfer_cnt <= w_xfer_done ? {XFER_W{1'b0}} : (r_xfer_cnt + XFER_W'(1));
            end else begin
                r_xfer_cnt <= r_xfer_cnt;
            end
        end
    end

    // Fire cooldown: a new accept reloads it even on a bullet-tick cycle
    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_cool     <= {COOL_W{1'b0}};
            r_fire_req <= 1'b0;
        end else begin
            r_fire_req <= w_fire_accept;
            if (w_fire_accept) begin
                r_cool <= COOL_W'(FIRE_COOLDOWN);
            end else if (w_bullet_wrap && (r_cool != {COOL_W{1'b0}})) begin
                r_cool <= r_cool - COOL_W'(1);
            end else begin
                r_cool <= r_cool;
            end
        end
    end

    assign state        = r_state;
    assign level        = r_level;
    assign clear_field  = r_clear;
    assign game_over    = r_over;
    assign game_won     = r_won;
    assign ship_tick    = r_ship_tick;
    assign bullet_tick  = r_bullet_tick;
    assign monster_tick = r_mon_tick;
    assign fire_req     = r_fire_req;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with small dividers.
module tb_game_sequencer;
    localparam int SHIP_DIV = 4, BULLET_DIV = 2, MON_BASE = 10, MON_STEP = 3, MON_MIN = 3;
    localparam int COOL = 2, MAXL = 3, XFER = 2;

    logic clk = 1'b0;
    logic rst, start, pause, fire, all_cleared, breach;
    logic [2:0] state;
    logic [1:0] level;
    logic ship_tick, bullet_tick, monster_tick, fire_req, clear_field, game_over, game_won;

    always #5 clk = ~clk;

    game_sequencer #(
        .SHIP_DIV(SHIP_DIV), .BULLET_DIV(BULLET_DIV), .MON_DIV_BASE(MON_BASE),
        .MON_DIV_STEP(MON_STEP), .MON_DIV_MIN(MON_MIN), .FIRE_COOLDOWN(COOL),
        .MAX_LEVEL(MAXL), .XFER_TICKS(XFER)
    ) dut (
        .iVGA_CLK(clk), .rst(rst), .start(start), .pause(pause), .fire(fire),
        .all_cleared(all_cleared), .breach(breach), .state(state),
        .ship_tick(ship_tick), .bullet_tick(bullet_tick), .monster_tick(monster_tick),
        .fire_req(fire_req), .clear_field(clear_field), .level(level),
        .game_over(game_over), .game_won(game_won)
    );

    typedef struct {
        int id;
        bit rst, start, pause, fire, clr, brk;
        int st; bit clrf; int lvl; bit freq, over, won;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t sb[$];
    vec_t tbl_start[$];
    vec_t tbl_fire[$];

    function automatic vec_t mk(int id, bit r, bit s, bit p, bit f, bit c, bit b,
                                int st, bit cf, int lv, bit fr, bit ov, bit wn);
        vec_t v;
        v.id = id; v.rst = r; v.start = s; v.pause = p; v.fire = f; v.clr = c; v.brk = b;
        v.st = st; v.clrf = cf; v.lvl = lv; v.freq = fr; v.over = ov; v.won = wn;
        return v;
    endfunction

    function automatic int mon_period(int l);
        int p;
        p = MON_BASE - l * MON_STEP;
        if (p < MON_MIN) p = MON_MIN;
        return p;
    endfunction

    function automatic bit tick_of(int which);
        case (which)
            0: return ship_tick;
            1: return bullet_tick;
            default: return monster_tick;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; start = 1'b0; pause = 1'b0; fire = 1'b0; all_cleared = 1'b0; breach = 1'b0;
    endtask

    // Drive one vector, queue its expectation, compare after the next edge.
    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst; start = v.start; pause = v.pause; fire = v.fire;
        all_cleared = v.clr; breach = v.brk;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("v%0d state", e.id), state, e.st);
        chk($sformatf("v%0d clear_field", e.id), clear_field, e.clrf);
        if (e.lvl >= 0) chk($sformatf("v%0d level", e.id), level, e.lvl);
        chk($sformatf("v%0d fire_req", e.id), fire_req, e.freq);
        chk($sformatf("v%0d game_over", e.id), game_over, e.over);
        chk($sformatf("v%0d game_won", e.id), game_won, e.won);
    endtask

    task automatic zero_ticks(input string name);
        chk({name, " ship_tick"}, ship_tick, 0);
        chk({name, " bullet_tick"}, bullet_tick, 0);
        chk({name, " monster_tick"}, monster_tick, 0);
    endtask

    task automatic wait_tick(input int which);
        int n = 0;
        bit seen = 1'b0;
        idle();
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = tick_of(which);
        end
        chk($sformatf("sync tick%0d seen", which), seen, 1);
    endtask

    task automatic measure(input int which, input int exp, input string name);
        int n = 0;
        bit seen = 1'b0;
        wait_tick(which);
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = tick_of(which);
        end
        chk(name, n, exp);
    endtask

    // Check period at level l, clear the field on a monster tick, time XFER.
    task automatic level_up(input int l);
        int n, strobes;
        measure(2, mon_period(l), $sformatf("monster period L%0d", l));
        apply(mk(100 + l, 0, 0, 0, 0, 1, 0, 3, 0, l, 0, 0, 0));
        idle();
        n = 1;
        strobes = ship_tick + bullet_tick + monster_tick;
        while (state == 3'd3 && n < 1000) begin
            @(negedge clk);
            if (state == 3'd3) begin
                n++;
                strobes += ship_tick + bullet_tick + monster_tick;
            end
        end
        chk($sformatf("xfer length L%0d", l), n, XFER * mon_period(l));
        chk($sformatf("xfer strobes L%0d", l), strobes, 0);
        chk($sformatf("xfer exit state L%0d", l), state, 1);
        chk($sformatf("xfer exit level L%0d", l), level, l + 1);
        chk($sformatf("xfer exit clear L%0d", l), clear_field, 1);
        @(negedge clk);
        chk($sformatf("xfer clear width L%0d", l), clear_field, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, strobes;
        // id, rst, start, pause, fire, clr, brk, state, clear, level, fire_req, over, won
        tbl_start.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_start.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_start.push_back(mk(2, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl_start.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_start.push_back(mk(4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl_start.push_back(mk(5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl_start.push_back(mk(6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++)
            tbl_fire.push_back(mk(10 + i, 0, 0, 0, 1, 0, 0, 1, 0, 0, (i == 0), 0, 0));
        tbl_fire.push_back(mk(30, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl_fire.push_back(mk(31, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl_fire.push_back(mk(32, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl_fire.push_back(mk(33, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            tbl_fire.push_back(mk(34 + i, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl_fire.push_back(mk(40, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl_fire.push_back(mk(41, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        rst = 1'b1; start = 1'b0; pause = 1'b0; fire = 1'b0; all_cleared = 1'b0; breach = 1'b0;
        @(negedge clk);
        for (int i = 0; i < tbl_start.size(); i++) begin
            apply(tbl_start[i]);
            if (i == 1) zero_ticks("reset");
        end

        measure(0, SHIP_DIV, "ship period");
        measure(1, BULLET_DIV, "bullet period");
        measure(2, MON_BASE, "monster period L0 start");

        for (int i = 0; i < tbl_fire.size(); i++) apply(tbl_fire[i]);

        // Pause with the ship prescaler one step past its wrap.
        wait_tick(0);
        @(negedge clk);
        apply(mk(50, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            apply(mk(51 + i, 0, (i >= 10 && i < 14), 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
            strobes += ship_tick + bullet_tick + monster_tick;
        end
        chk("paused strobes", strobes, 0);
        apply(mk(101, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        idle();
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ship_tick) break;
        end
        chk("ship resume latency", n, SHIP_DIV - 1);

        for (int l = 0; l < MAXL; l++) level_up(l);
        measure(2, mon_period(MAXL), "monster period floor");
        apply(mk(200, 0, 0, 0, 0, 1, 0, 5, 0, MAXL, 0, 0, 1));
        apply(mk(201, 0, 0, 0, 0, 0, 0, 5, 0, MAXL, 0, 0, 1));
        apply(mk(202, 0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0));
        apply(mk(203, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0));

        // breach beats all_cleared, level is kept
        apply(mk(210, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        apply(mk(211, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        level_up(0);
        apply(mk(212, 0, 0, 0, 0, 1, 1, 4, 0, 1, 0, 1, 0));
        apply(mk(213, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 1, 0));
        apply(mk(214, 0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0));
        apply(mk(215, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0));

        // reset in the middle of XFER with the fire cooldown still loaded
        apply(mk(220, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        apply(mk(221, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        level_up(0);
        wait_tick(2);
        apply(mk(222, 0, 0, 0, 1, 1, 0, 3, 0, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) apply(mk(223 + i, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0));
        apply(mk(230, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        zero_ticks("mid-xfer reset");
        apply(mk(231, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(232, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        apply(mk(233, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
        apply(mk(234, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
